tmds_symbol_scheduler: RTL and testbench

Schedules 10-bit TMDS symbols into the three lane serializers of the video output path. Owns the 0–9 symbol phase and fetches one 3-lane word per symbol period from the upstream encoder through a valid/ready handshake. Inserts control (idle) symbols during startup, while disabled, and on upstream underflow. Sits between the TMDS encoders and the three `serializer` instances, which share its clock and reset.

---
 rtl/tmds_pkg.sv | 22 ++
 rtl/symbol_phase_counter.sv | 29 ++
 rtl/tmds_symbol_scheduler.sv | 119 +++++++++++
 tb/tb_tmds_symbol_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS constants and scheduler types.
// Used by the symbol scheduler and the lane encoders.
package tmds_pkg;

   localparam int SYM_W = 10;
   localparam int LANES = 3;

   localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

   localparam logic [3:0] PHASE_FETCH = 4'd8;
   localparam logic [3:0] PHASE_LAST  = 4'd9;

   typedef enum logic [1:0] {
      STARTUP = 2'd0,
      RUN     = 2'd1,
      IDLE    = 2'd2
   } sched_state_t;

endpackage

// File: rtl/symbol_phase_counter.sv
// Free-running 0..9 symbol phase counter with fetch/load strobes.
// Shared by the scheduler and the encoders to stay in lockstep.
module symbol_phase_counter
   import tmds_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   output logic [3:0] phase_o,
   output logic       fetch_o,
   output logic       load_o
);

   logic [3:0] phase;

   // Count 0..9 and wrap; reset realigns with the serializers.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         phase <= 4'd0;
      else if (phase == PHASE_LAST)
         phase <= 4'd0;
      else
         phase <= phase + 4'd1;
   end

   assign phase_o = phase;
   assign fetch_o = (phase == PHASE_FETCH);
   assign load_o  = (phase == PHASE_LAST);

endmodule

// File: rtl/tmds_symbol_scheduler.sv
// Feeds one 3-lane TMDS word per symbol period to the serializers,
// substituting idle control symbols at startup, when disabled, on underflow.
module tmds_symbol_scheduler
   import tmds_pkg::*;
#(
   parameter int unsigned      STARTUP_SYMBOLS = 16,
   parameter logic [SYM_W-1:0] CTRL_IDLE       = CTRL_00,
   parameter int unsigned      UFLOW_W         = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     s_valid_i,
   input  logic [LANES*SYM_W-1:0]   s_data_i,
   output logic                     s_ready_o,
   output logic [LANES*SYM_W-1:0]   d_o,
   output logic [3:0]               phase_o,
   output logic                     running_o,
   output logic                     underflow_o,
   output logic [UFLOW_W-1:0]       underflow_cnt_o
);

   localparam logic [LANES*SYM_W-1:0] IDLE_WORD = {LANES{CTRL_IDLE}};
   localparam logic [7:0] LAST_SYM = 8'(STARTUP_SYMBOLS - 1);

   sched_state_t state;
   sched_state_t state_nxt;

   logic [3:0]             phase;
   logic                   fetch;
   logic                   load;
   logic [7:0]             sym_cnt;
   logic                   last_sym;
   logic                   ready;
   logic                   take;
   logic                   miss;
   logic [LANES*SYM_W-1:0] d;
   logic                   running;
   logic                   uflow;
   logic [UFLOW_W-1:0]     ucnt;

   symbol_phase_counter u_phase (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .phase_o (phase),
      .fetch_o (fetch),
      .load_o  (load)
   );

   assign last_sym = (sym_cnt == LAST_SYM);

   // State register; transitions only take effect at FETCH.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= STARTUP;
      else
         state <= state_nxt;
   end

   // Next state: enable is only looked at on FETCH.
   always_comb begin
      state_nxt = state;
      if (fetch) begin
         unique case (state)
            STARTUP: begin
               if (last_sym)
                  state_nxt = enable_i ? RUN : IDLE;
            end
            RUN: begin
               if (!enable_i)
                  state_nxt = IDLE;
            end
            IDLE: begin
               if (enable_i)
                  state_nxt = RUN;
            end
            default: state_nxt = STARTUP;
         endcase
      end
   end

   // Handshake decode: ready never looks at s_valid_i.
   always_comb begin
      ready = fetch && (state == RUN) && enable_i;
      take  = ready && s_valid_i;
      miss  = ready && !s_valid_i;
   end

   // Output word, run flag, underflow pulse/count and startup counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d       <= IDLE_WORD;
         running <= 1'b0;
         uflow   <= 1'b0;
         ucnt    <= '0;
         sym_cnt <= 8'd0;
      end else begin
         if (fetch) begin
            d       <= take ? s_data_i : IDLE_WORD;
            running <= ready;
            uflow   <= miss;
            if (miss && (ucnt != '1))
               ucnt <= ucnt + UFLOW_W'(1);
         end else if (load) begin
            uflow <= 1'b0;
         end
         if (fetch && (state == STARTUP))
            sym_cnt <= sym_cnt + 8'd1;
      end
   end

   assign s_ready_o       = ready;
   assign d_o             = d;
   assign phase_o         = phase;
   assign running_o       = running;
   assign underflow_o     = uflow;
   assign underflow_cnt_o = ucnt;

endmodule

// File: tb/tb_tmds_symbol_scheduler.sv
// Bench for tmds_symbol_scheduler: directed table, corner sequences,
// and random traffic against a period-level reference model.
module tb_tmds_symbol_scheduler;

   localparam int N = 4;
   localparam logic [29:0] IDLE3 = {3{10'b1101010100}};
   localparam logic [29:0] W1 = {10'h3FF, 10'h000, 10'h155};
   localparam logic [29:0] W2 = {10'h0AA, 10'h2AA, 10'h001};
   localparam logic [29:0] W3 = {10'h155, 10'h3FF, 10'h000};

   typedef struct {
      logic        en;
      logic        val;
      logic [29:0] data;
      logic        rdy;
      logic [29:0] d;
      logic        uf;
      logic [1:0]  cnt;
      logic        run;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        val;
   logic [29:0] data;
   logic        ready;
   logic [29:0] d;
   logic [3:0]  phase;
   logic        running;
   logic        uf;
   logic [1:0]  cnt;

   int ncmp;
   int nfail;
   int cyc;
   logic [9:0] ser;

   tmds_symbol_scheduler #(
      .STARTUP_SYMBOLS (N),
      .CTRL_IDLE       (10'b1101010100),
      .UFLOW_W         (2)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .enable_i        (en),
      .s_valid_i       (val),
      .s_data_i        (data),
      .s_ready_o       (ready),
      .d_o             (d),
      .phase_o         (phase),
      .running_o       (running),
      .underflow_o     (uf),
      .underflow_cnt_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index since the last reset edge.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Lane0 serializer stand-in: loads at the end of phase 9, LSB first.
   always @(posedge clk) begin
      if (cyc % 10 == 9) ser <= d[9:0];
      else ser <= {1'b0, ser[9:1]};
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at cyc %0d: got %h expected %h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int c);
      int guard;
      guard = 0;
      while (cyc != c && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != c) chk("wait_timeout", 64'(cyc), 64'(c));
   endtask

   // Checks cycles 1..49 after a reset with enable/valid high, data W1.
   task automatic startup_seq();
      for (int c = 1; c <= 49; c++) begin
         @(negedge clk);
         if (c < 49) begin
            chk("start_d", 64'(d), 64'(IDLE3));
            chk("start_rdy", 64'(ready), 64'(c == 48));
            chk("start_run", 64'(running), 64'(0));
         end else begin
            chk("start_phase", 64'(phase), 64'(9));
            chk("first_word", 64'(d), 64'(W1));
            chk("run_rise", 64'(running), 64'(1));
         end
      end
   endtask

   function automatic vec_t mk(logic e, logic v, logic [29:0] x,
                               logic r, logic [29:0] y, logic u,
                               logic [1:0] c, logic rn);
      vec_t t;
      t.en = e; t.val = v; t.data = x; t.rdy = r;
      t.d = y; t.uf = u; t.cnt = c; t.run = rn;
      return t;
   endfunction

   // Reference model: RUN means startup done and enable seen at last FETCH.
   int          m_n;
   int          m_fetches;
   logic        m_prev_en;
   logic [29:0] m_d;
   logic        m_run;
   logic        m_uf;
   int          m_cnt;

   function automatic logic m_rdy(logic e);
      return (m_n % 10 == 8) && (m_fetches >= N) && m_prev_en && e;
   endfunction

   task automatic m_reset();
      m_n = 0; m_fetches = 0; m_prev_en = 1'b0;
      m_d = IDLE3; m_run = 1'b0; m_uf = 1'b0; m_cnt = 0;
   endtask

   task automatic m_step(input logic e, input logic v, input logic [29:0] x);
      logic r;
      logic nu;
      r = m_rdy(e);
      nu = 1'b0;
      if (m_n % 10 == 8) begin
         m_d = (r && v) ? x : IDLE3;
         m_run = r;
         nu = r && !v;
         if (nu && m_cnt < 3) m_cnt++;
         m_fetches++;
         m_prev_en = e;
      end
      m_uf = nu;
      m_n++;
   endtask

   vec_t tbl [9];
   logic [1:0] sat_exp [5];
   logic [9:0] lane0;

   initial begin
      ncmp = 0;
      nfail = 0;
      tbl[0] = mk(1, 1, W3, 1, W3,    0, 2'd0, 1);
      tbl[1] = mk(1, 0, W1, 1, IDLE3, 1, 2'd1, 1);
      tbl[2] = mk(1, 1, W1, 1, W1,    0, 2'd1, 1);
      tbl[3] = mk(0, 1, W2, 0, IDLE3, 0, 2'd1, 0);
      tbl[4] = mk(0, 1, W2, 0, IDLE3, 0, 2'd1, 0);
      tbl[5] = mk(1, 1, W2, 0, IDLE3, 0, 2'd1, 0);
      tbl[6] = mk(1, 1, W3, 1, W3,    0, 2'd1, 1);
      tbl[7] = mk(1, 0, W3, 1, IDLE3, 1, 2'd2, 1);
      tbl[8] = mk(1, 1, W2, 1, W2,    0, 2'd2, 1);
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      // Reset state
      rst = 1'b1; en = 1'b1; val = 1'b1; data = W1;
      repeat (2) @(negedge clk);
      chk("rst_phase", 64'(phase), 64'(0));
      chk("rst_d", 64'(d), 64'(IDLE3));
      chk("rst_rdy", 64'(ready), 64'(0));
      chk("rst_run", 64'(running), 64'(0));
      chk("rst_uf", 64'(uf), 64'(0));
      chk("rst_cnt", 64'(cnt), 64'(0));
      rst = 1'b0;

      startup_seq();

      // Serial order of the first word, and the next word at cycle 59
      data = W2;
      lane0 = W1[9:0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("ser_bit", 64'(ser[0]), 64'(lane0[i]));
         if (i == 8) chk("w2_rdy", 64'(ready), 64'(1));
      end
      chk("w2_d", 64'(d), 64'(W2));

      // Directed table, one record per symbol period from period 6
      for (int k = 0; k < 9; k++) begin
         wait_cyc(10 * (6 + k) + 3);
         en = tbl[k].en; val = tbl[k].val; data = tbl[k].data;
         wait_cyc(10 * (6 + k) + 8);
         chk("tbl_rdy", 64'(ready), 64'(tbl[k].rdy));
         chk("tbl_uf_pre", 64'(uf), 64'(0));
         wait_cyc(10 * (6 + k) + 9);
         chk("tbl_d", 64'(d), 64'(tbl[k].d));
         chk("tbl_uf", 64'(uf), 64'(tbl[k].uf));
         chk("tbl_cnt", 64'(cnt), 64'(tbl[k].cnt));
         chk("tbl_run", 64'(running), 64'(tbl[k].run));
      end
      wait_cyc(150);
      chk("uf_clear", 64'(uf), 64'(0));

      // One-cycle reset at phase 5 of a RUN period
      en = 1'b1; val = 1'b1; data = W1;
      wait_cyc(155);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_phase", 64'(phase), 64'(0));
      chk("mrst_d", 64'(d), 64'(IDLE3));
      chk("mrst_rdy", 64'(ready), 64'(0));
      chk("mrst_cnt", 64'(cnt), 64'(0));
      chk("mrst_run", 64'(running), 64'(0));
      startup_seq();

      // Five consecutive underflows saturate a 2-bit counter
      val = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_cyc(10 * (5 + k) + 9);
         chk("sat_uf", 64'(uf), 64'(1));
         chk("sat_d", 64'(d), 64'(IDLE3));
         chk("sat_cnt", 64'(cnt), 64'(sat_exp[k]));
      end

      // Random traffic against the reference model
      rst = 1'b1; en = 1'b1; val = 1'b1; data = 30'(W2);
      repeat (2) @(negedge clk);
      m_reset();
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         m_step(en, val, data);
         @(posedge clk);
         #1;
         if ($urandom_range(0, 39) == 0) en = ~en;
         val = ($urandom_range(0, 9) < 8);
         data = 30'($urandom);
         @(negedge clk);
         chk("rand", {25'd0, phase, d, ready, running, uf, cnt},
             {25'd0, 4'(m_n % 10), m_d, m_rdy(en), m_run, m_uf,
              2'(m_cnt)});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
